// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_pkg
//  Description : Shared types and helpers for the round-robin bus arbiter.
//  Revision    : 1.0  - initial release
// ============================================================================
package bus_arbiter_pkg;

    // One-hot encoded arbiter states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'b001,
        ST_GRANTED  = 3'b010,
        ST_WAIT_RSP = 3'b100
    } arb_state_t;

    // Width of an index into a vector of n entries (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Searches upward from
//                (last owner + 1) with wrap-around and returns the first
//                requesting index as both one-hot and binary.
//  Revision    : 1.0  - initial release
// ============================================================================
module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_last_idx,
    output logic [NUM_MASTERS-1:0] o_winner_oh,
    output logic [IDX_W-1:0]       o_winner_idx,
    output logic                   o_any_valid
);

    // Walk the candidates in priority order; the first requester wins
    always_comb begin : p_search
        logic [IDX_W:0]   w_sum;
        logic [IDX_W-1:0] w_cand;
        logic             w_found;
        o_winner_oh  = '0;
        o_winner_idx = '0;
        o_any_valid  = |i_req;
        w_found      = 1'b0;
        w_sum        = '0;
        w_cand       = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            // last + k never exceeds 2*NUM_MASTERS-1, so one subtraction wraps it
            w_sum = {1'b0, i_last_idx} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_MASTERS)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_MASTERS);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found              = 1'b1;
                o_winner_oh[w_cand]  = 1'b1;
                o_winner_idx         = w_cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Round-robin arbiter for a shared bus. Grants one master,
//                tracks write/read completion, holds read-response ownership
//                and aborts stalled transactions with a timeout pulse.
//  Revision    : 1.0  - initial release
// ============================================================================
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic                   i_bus_rnw,
    input  logic                   i_bus_data_valid,
    output logic [NUM_MASTERS-1:0] o_gnt,
    output logic [NUM_MASTERS-1:0] o_rsp,
    output logic                   o_busy,
    output logic                   o_timeout
);

    localparam int c_IDX_W = idx_width(NUM_MASTERS);
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_t               r_state;
    arb_state_t               w_next_state;
    logic [c_IDX_W-1:0]       r_owner_idx;
    logic [NUM_MASTERS-1:0]   r_owner_oh;
    logic [c_CNT_W-1:0]       r_cnt;
    logic                     r_timeout;

    logic [NUM_MASTERS-1:0]   w_pick_oh;
    logic [c_IDX_W-1:0]       w_pick_idx;
    logic                     w_pick_any;
    logic                     w_load_owner;
    logic                     w_next_timeout;
    logic                     w_owner_req;
    logic                     w_cnt_max;
    logic                     w_write_done;
    logic                     w_read_data;

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_IDX_W)
    ) u_rr_pick (
        .i_req        (i_req),
        .i_last_idx   (r_owner_idx),
        .o_winner_oh  (w_pick_oh),
        .o_winner_idx (w_pick_idx),
        .o_any_valid  (w_pick_any)
    );

    assign w_owner_req  = |(i_req & r_owner_oh);
    assign w_cnt_max    = (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_write_done = i_bus_data_valid & ~i_bus_rnw;
    assign w_read_data  = i_bus_data_valid &  i_bus_rnw;

    // State register and registered timeout pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_timeout <= w_next_timeout;
        end
    end

    // Next-state logic; exit events are tested before the timeout so they win
    always_comb begin
        w_next_state   = r_state;
        w_next_timeout = 1'b0;
        w_load_owner   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_next_state = ST_GRANTED;
                    w_load_owner = 1'b1;
                end
            end
            ST_GRANTED: begin
                if (w_write_done) begin
                    w_next_state = ST_IDLE;
                end else if (w_read_data) begin
                    w_next_state = ST_WAIT_RSP;
                end else if (!w_owner_req) begin
                    w_next_state = ST_IDLE;
                end else if (w_cnt_max) begin
                    w_next_state   = ST_IDLE;
                    w_next_timeout = 1'b1;
                end
            end
            ST_WAIT_RSP: begin
                if (w_read_data) begin
                    w_next_state = ST_IDLE;
                end else if (w_cnt_max) begin
                    w_next_state   = ST_IDLE;
                    w_next_timeout = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Owner capture at grant time; reset pointer makes index 0 win first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_idx <= c_IDX_W'(NUM_MASTERS - 1);
            r_owner_oh  <= '0;
        end else if (w_load_owner) begin
            r_owner_idx <= w_pick_idx;
            r_owner_oh  <= w_pick_oh;
        end
    end

    // Cycle counter: runs while staying in a busy state, clears on any change
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state != ST_IDLE) && (w_next_state == r_state)) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_gnt     = (r_state == ST_GRANTED)  ? r_owner_oh : '0;
    assign o_rsp     = (r_state == ST_WAIT_RSP) ? r_owner_oh : '0;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_timeout = r_timeout;

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Directed scoreboard bench for bus_arbiter (4 masters,
//                16-cycle timeout). Each stimulus cycle pushes the outputs
//                expected after the next clock edge; a monitor pops and
//                compares them one cycle later.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int c_N   = 4;
    localparam int c_TMO = 16;

    logic           clk;
    logic           rst;
    logic [c_N-1:0] req;
    logic           rnw;
    logic           dv;
    logic [c_N-1:0] gnt;
    logic [c_N-1:0] rsp;
    logic           busy;
    logic           tmo;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] rsp;
        logic       busy;
        logic       tmo;
        int         id;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_id  = 0;

    bus_arbiter #(
        .NUM_MASTERS    (c_N),
        .TIMEOUT_CYCLES (c_TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_req            (req),
        .i_bus_rnw        (rnw),
        .i_bus_data_valid (dv),
        .o_gnt            (gnt),
        .o_rsp            (rsp),
        .o_busy           (busy),
        .o_timeout        (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and record the outputs expected after the edge
    task automatic cyc(input logic r, input logic [3:0] rq, input logic d,
                       input logic rw, input logic [3:0] eg, input logic [3:0] er,
                       input logic eb, input logic et);
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        dv  = d;
        rnw = rw;
        step_id++;
        e.gnt  = eg;
        e.rsp  = er;
        e.busy = eb;
        e.tmo  = et;
        e.id   = step_id;
        q_exp.push_back(e);
    endtask

    // Monitor: compare the DUT outputs shortly after each active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n_checks++;
                if ({gnt, rsp, busy, tmo} === {e.gnt, e.rsp, e.busy, e.tmo}) begin
                    n_pass++;
                end else begin
                    $display("FAIL step%0d: got gnt=%b rsp=%b busy=%b tmo=%b, expected gnt=%b rsp=%b busy=%b tmo=%b",
                             e.id, gnt, rsp, busy, tmo, e.gnt, e.rsp, e.busy, e.tmo);
                end
            end
        end
    end

    initial begin
        logic [3:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1;
        req = '0;
        dv  = 1'b0;
        rnw = 1'b0;

        // Reset state
        cyc(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);
        cyc(1, 4'b0110, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // Two requesters: index 1 first, write, one idle cycle, then index 2
        cyc(0, 4'b0110, 0, 0, 4'b0010, 4'b0000, 1, 0);
        cyc(0, 4'b0110, 1, 0, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 4'b0100, 0, 0, 4'b0100, 4'b0000, 1, 0);
        cyc(0, 4'b0100, 1, 0, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // All four requesting with single-cycle writes after a fresh reset
        cyc(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 4'b1111, 0, 0, order[k], 4'b0000, 1, 0);
            cyc(0, 4'b1111, 1, 0, 4'b0000,  4'b0000, 0, 0);
        end
        cyc(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // Read by master 2, master 3 requests meanwhile, response 5 cycles later
        cyc(0, 4'b0100, 0, 0, 4'b0100, 4'b0000, 1, 0);
        cyc(0, 4'b0100, 1, 1, 4'b0000, 4'b0100, 1, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 4'b1000, 0, 0, 4'b0000, 4'b0100, 1, 0);
        end
        cyc(0, 4'b1000, 1, 1, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 4'b1000, 0, 0, 4'b1000, 4'b0000, 1, 0);
        cyc(0, 4'b1000, 1, 0, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // Read with no response: timeout pulse 16 cycles after WAIT_RSP entry
        cyc(0, 4'b0100, 0, 0, 4'b0100, 4'b0000, 1, 0);
        cyc(0, 4'b0100, 1, 1, 4'b0000, 4'b0100, 1, 0);
        for (int k = 0; k < c_TMO - 1; k++) begin
            cyc(0, 4'b0000, 0, 0, 4'b0000, 4'b0100, 1, 0);
        end
        cyc(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 1);
        cyc(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // Response on the final counter value: clean exit, no timeout
        cyc(0, 4'b0100, 0, 0, 4'b0100, 4'b0000, 1, 0);
        cyc(0, 4'b0100, 1, 1, 4'b0000, 4'b0100, 1, 0);
        for (int k = 0; k < c_TMO - 1; k++) begin
            cyc(0, 4'b0000, 0, 0, 4'b0000, 4'b0100, 1, 0);
        end
        cyc(0, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // Owner drops request while granted: abandon without timeout
        cyc(0, 4'b0001, 0, 0, 4'b0001, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // Grant held with no data phase: timeout from GRANTED
        cyc(0, 4'b0010, 0, 0, 4'b0010, 4'b0000, 1, 0);
        for (int k = 0; k < c_TMO - 1; k++) begin
            cyc(0, 4'b0010, 0, 0, 4'b0010, 4'b0000, 1, 0);
        end
        cyc(0, 4'b0010, 0, 0, 4'b0000, 4'b0000, 0, 1);
        cyc(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // Reset during WAIT_RSP, then index 0 favoured, then index 3
        cyc(0, 4'b0100, 0, 0, 4'b0100, 4'b0000, 1, 0);
        cyc(0, 4'b0100, 1, 1, 4'b0000, 4'b0100, 1, 0);
        cyc(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 4'b1001, 0, 0, 4'b0001, 4'b0000, 1, 0);
        cyc(0, 4'b1001, 1, 0, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 4'b1000, 0, 0, 4'b1000, 4'b0000, 1, 0);
        cyc(0, 4'b1000, 1, 0, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0);

        // Drain: every pushed expectation must have been consumed
        @(posedge clk);
        #3;
        n_checks++;
        if (q_exp.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bus_arbiter
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting bus masters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum cycles a grant or response wait may last (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_req  input  NUM_MASTERS  per-master bus request, level, held until served.
REQ-006 SHALL have port i_bus_rnw  input  1  shared bus control[1] (read-not-write).
REQ-007 SHALL have port i_bus_data_valid  input  1  shared bus control[0] (data valid).
REQ-008 SHALL have port o_gnt  output  NUM_MASTERS  one-hot bus grant; grantee may drive bus.
REQ-009 SHALL have port o_rsp  output  NUM_MASTERS  one-hot response-owner flag; owner captures read data, must not drive bus.
REQ-010 SHALL have port o_busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port o_timeout  output  1  one-cycle pulse when a transaction is aborted by timeout.

Function
REQ-012 SHALL implement states IDLE, GRANTED, WAIT_RSP; all outputs registered or decoded from registered state only.
REQ-013 IDLE: if any i_req bit high, SHALL select winner round-robin, record owner, enter GRANTED next cycle (req-to-gnt latency 1 cycle).
REQ-014 Round-robin SHALL search from index (last_owner+1) mod NUM_MASTERS upward with wrap; pointer resets to index 0 having highest priority.
REQ-015 o_gnt SHALL be owner one-hot in GRANTED only, zero otherwise; o_rsp SHALL be owner one-hot in WAIT_RSP only.
REQ-016 GRANTED with i_bus_data_valid=1 and i_bus_rnw=0 (write issued) SHALL return to IDLE next cycle.
REQ-017 GRANTED with i_bus_data_valid=1 and i_bus_rnw=1 (read issued) SHALL enter WAIT_RSP next cycle.
REQ-018 GRANTED with owner's i_req dropped and no data_valid SHALL return to IDLE (abandon, no timeout pulse).
REQ-019 WAIT_RSP with i_bus_data_valid=1 and i_bus_rnw=1 (slave response) SHALL return to IDLE next cycle.
REQ-020 Cycle counter SHALL clear on entry to GRANTED and WAIT_RSP, increment each cycle in them; reaching TIMEOUT_CYCLES-1 without exit event SHALL force IDLE and pulse o_timeout once.
REQ-021 Exit event and timeout on same cycle: exit event SHALL win, no o_timeout.
REQ-022 Release to IDLE SHALL insert exactly one IDLE cycle before next grant, even with requests pending (bus turnaround).
REQ-023 Requests from non-owners during GRANTED/WAIT_RSP SHALL be ignored until IDLE; no request is lost while held.
REQ-024 Counter width SHALL be $clog2(TIMEOUT_CYCLES)+1 bits; no wrap possible.

Reset
REQ-025 rst=1 at any clock edge, including mid-transaction, SHALL force IDLE, o_gnt=0, o_rsp=0, o_busy=0, o_timeout=0, counter=0, last_owner=NUM_MASTERS-1.
REQ-026 First arbitration after reset SHALL favour index 0.

Structure
REQ-027 State enum (one-hot, 3 bits) SHALL live in shared package bus_arbiter_pkg.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req vector, last owner index; outputs one-hot winner, index, any_valid).

Verification
REQ-029 Reset, then i_req=4'b0110 held -> o_gnt=4'b0010 one cycle later; after write (dv=1,rnw=0) one IDLE cycle then o_gnt=4'b0100.
REQ-030 All four requesting continuously with single-cycle writes -> grant order 0,1,2,3,0, each grant separated by one IDLE cycle.
REQ-031 Master 2 issues read (dv=1,rnw=1), slave responds 5 cycles later -> o_rsp=4'b0100 for those cycles, o_gnt=0, then IDLE.
REQ-032 Read issued, no slave response -> o_timeout pulse exactly TIMEOUT_CYCLES (16) cycles after WAIT_RSP entry, state IDLE.
REQ-033 Response arrives on counter=15 -> clean return to IDLE, o_timeout stays 0.
REQ-034 rst asserted during WAIT_RSP -> next cycle all outputs 0; subsequent i_req=4'b1001 -> o_gnt=4'b0001.
